// File: rtl/zero_count_accum.sv
// Per-frame accumulator of per-byte zero counts.
// Produces a saturating zero-bit total, a byte count, and sticky overflow/error flags.
module zero_count_accum #(
    parameter int SUM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_count,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [SUM_W-1:0] out_bytes,
    output logic             out_ovf,
    output logic             out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [SUM_W-1:0]   run_sum;
    logic [SUM_W-1:0]   run_bytes;
    logic               run_ovf;
    logic               run_err;

    logic               xfer;
    logic [3:0]         contrib;
    logic               bad_count;
    logic [SUM_W-1:0]   base_sum;
    logic [SUM_W-1:0]   base_bytes;
    logic               base_ovf;
    logic               base_err;
    logic [SUM_W:0]     sum_ext;
    logic [SUM_W:0]     bytes_ext;
    logic [SUM_W-1:0]   nxt_sum;
    logic [SUM_W-1:0]   nxt_bytes;
    logic               nxt_ovf;
    logic               nxt_err;

    // in_ready depends on the state register alone, so no path from in_valid or out_ready.
    assign in_ready = (state != HOLD);
    assign xfer     = in_valid && in_ready;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        bad_count  = (in_count > 4'd8);
        contrib    = bad_count ? 4'd8 : in_count;
        base_sum   = run_sum;
        base_bytes = run_bytes;
        base_ovf   = run_ovf;
        base_err   = run_err;
        // A byte accepted from IDLE opens a fresh frame with nothing carried over.
        if (state == IDLE) begin
            base_sum   = '0;
            base_bytes = '0;
            base_ovf   = 1'b0;
            base_err   = 1'b0;
        end
        sum_ext   = {1'b0, base_sum} + {{(SUM_W-3){1'b0}}, contrib};
        bytes_ext = {1'b0, base_bytes} + {{SUM_W{1'b0}}, 1'b1};
        nxt_sum   = sum_ext[SUM_W]   ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        nxt_bytes = bytes_ext[SUM_W] ? {SUM_W{1'b1}} : bytes_ext[SUM_W-1:0];
        nxt_ovf   = base_ovf | sum_ext[SUM_W] | bytes_ext[SUM_W];
        nxt_err   = base_err | bad_count;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_sum   <= '0;
            run_bytes <= '0;
            run_ovf   <= 1'b0;
            run_err   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_bytes <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (xfer) begin
                        run_sum   <= nxt_sum;
                        run_bytes <= nxt_bytes;
                        run_ovf   <= nxt_ovf;
                        run_err   <= nxt_err;
                        if (in_last) begin
                            out_sum   <= nxt_sum;
                            out_bytes <= nxt_bytes;
                            out_ovf   <= nxt_ovf;
                            out_err   <= nxt_err;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state     <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Outputs keep their last values after the handshake; only valid drops.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        run_sum   <= '0;
                        run_bytes <= '0;
                        run_ovf   <= 1'b0;
                        run_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/zero_count_accum.md
ZERO_COUNT_ACCUM -- requirements
Module: zero_count_accum

Interface
REQ-001 The block SHALL have parameter SUM_W, default 12, giving the width of the frame zero-sum and byte-count results.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream per-byte zero count is valid.
REQ-005 in_ready  output  1  block accepts in_count this cycle.
REQ-006 in_count  input  4  zero count of one byte (legal range 0..8).
REQ-007 in_last  input  1  marks the final byte of a frame.
REQ-008 out_valid  output  1  frame result is available.
REQ-009 out_ready  input  1  downstream accepts the frame result.
REQ-010 out_sum  output  SUM_W  total zero bits in the frame.
REQ-011 out_bytes  output  SUM_W  number of bytes in the frame.
REQ-012 out_ovf  output  1  out_sum or out_bytes saturated during the frame.
REQ-013 out_err  output  1  at least one in_count > 8 occurred in the frame.

Function
REQ-014 The FSM SHALL have three states: IDLE (no frame open), ACCUM (frame open), HOLD (result pending).
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD, decoded from state only, with no combinational path from in_valid or out_ready.
REQ-016 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; no other input value SHALL affect state.
REQ-017 On each transfer the accumulator SHALL add min(in_count, 8) to the running sum and add 1 to the running byte count.
REQ-018 A transfer with in_count > 8 SHALL set a sticky frame error flag and contribute 8 to the sum.
REQ-019 Each accumulator SHALL saturate at 2^SUM_W-1 rather than wrap; the first saturating add SHALL set a sticky frame overflow flag.
REQ-020 IDLE -> ACCUM SHALL occur on a transfer with in_last=0; the accumulators SHALL load with that byte's contribution, with no carry from the previous frame.
REQ-021 IDLE or ACCUM -> HOLD SHALL occur on a transfer with in_last=1, including a single-byte frame from IDLE.
REQ-022 On that edge, out_sum, out_bytes, out_ovf and out_err SHALL load the final values including the last byte, and out_valid SHALL be 1 from the next cycle (1-cycle latency from the last transfer).
REQ-023 In HOLD, out_valid SHALL stay 1 and all out_* values SHALL stay stable until a cycle with out_ready=1.
REQ-024 HOLD -> IDLE SHALL occur on a rising edge with out_valid=1 and out_ready=1; out_valid SHALL drop to 0 on that edge, and the running accumulators and flags SHALL clear.
REQ-025 No input SHALL be accepted in the cycle of the output handshake, because in_ready=0 in HOLD; input acceptance SHALL resume the following cycle.
REQ-026 After a handshake, out_sum, out_bytes, out_ovf and out_err SHALL keep their last values while out_valid=0.
REQ-027 In IDLE or ACCUM, out_ready SHALL be ignored.
REQ-028 In ACCUM, cycles with in_valid=0 SHALL leave all state unchanged; a frame has no timeout.

Reset
REQ-029 While rst_n=0, state SHALL be IDLE and out_valid, out_sum, out_bytes, out_ovf, out_err and all internal accumulators and flags SHALL be 0.
REQ-030 While rst_n=0, in_ready SHALL be 1, consistent with IDLE.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result with no output handshake.
REQ-032 The first transfer after rst_n deasserts SHALL start a fresh frame.

Verification
REQ-033 Bytes with counts 3,8,0,5 (last on 5), out_ready=1 -> out_valid 1 cycle after the last transfer; out_sum=16, out_bytes=4, ovf=0, err=0.
REQ-034 Single byte count 7 with in_last=1 from IDLE -> out_sum=7, out_bytes=1; in_ready=0 until the handshake, then 1.
REQ-035 Frame ends while out_ready=0 for 5 cycles -> out_valid and all outputs stable for 5 cycles; in_valid pulses during HOLD are not accepted; handshake on cycle 6.
REQ-036 in_count=12 then 4 (last) -> out_sum=12, out_err=1; the next frame reports out_err=0.
REQ-037 SUM_W=4, five bytes of count 8 -> out_sum=15, out_bytes=5, out_ovf=1.
REQ-038 rst_n pulled low after 2 bytes of a frame -> outputs 0, in_ready=1; the next frame 1,1 (last) -> out_sum=2, out_bytes=2.
